// File: rtl/request_encoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : request_encoder_arbiter
// Brief    : Arbitrates 8 request lines and drives the winning index onto the
//            (adr0, adr1, adr2, valid) bundle of the 3-to-8 select decoder.
//            Optional watchdog enabled by defining RR_ENC_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module request_encoder_arbiter #(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_x,
    input  logic       ack,
    output logic       adr0,
    output logic       adr1,
    output logic       adr2,
    output logic       valid,
    output logic       busy
`ifdef RR_ENC_TIMEOUT_EN
    ,
    output logic       timeout_err
`endif
);

    typedef enum logic [0:0] {
        c_IDLE  = 1'b0,
        c_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_adr;
    logic [2:0] w_adr_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [2:0] w_winner;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_chk_timeout
        $error("TIMEOUT_CYCLES must lie in 1..255");
    end

    // Winner selection only matters in IDLE; it is registered on the way out.
    if (FIXED_PRIO != 0) begin : g_fixed
        always_comb begin
            w_winner = 3'd0;
            for (int i = 7; i >= 0; i--) begin
                if (req_x[i]) begin
                    w_winner = 3'(i);
                end
            end
        end
    end else begin : g_rr
        logic [7:0] w_rot;

        // Rotate so bit 0 is the request at ptr, then take the lowest set bit.
        always_comb begin
            w_rot    = 8'({req_x, req_x} >> r_ptr);
            w_winner = r_ptr;
            for (int k = 7; k >= 0; k--) begin
                if (w_rot[k]) begin
                    w_winner = r_ptr + 3'(k);
                end
            end
        end
    end

`ifdef RR_ENC_TIMEOUT_EN
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_tmo;
    logic       w_tmo_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_adr_nxt   = r_adr;
        w_ptr_nxt   = r_ptr;
`ifdef RR_ENC_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = 1'b0;
`endif
        case (r_state)
            c_IDLE: begin
                if (|req_x) begin
                    w_state_nxt = c_GRANT;
                    w_adr_nxt   = w_winner;
`ifdef RR_ENC_TIMEOUT_EN
                    w_cnt_nxt   = 8'd0;
`endif
                end
            end
            c_GRANT: begin
                // ack takes precedence over a watchdog expiry in the same cycle.
                if (ack) begin
                    w_state_nxt = c_IDLE;
                    w_ptr_nxt   = r_adr + 3'd1;
`ifdef RR_ENC_TIMEOUT_EN
                end else if (r_cnt == c_TMO_LAST) begin
                    w_state_nxt = c_IDLE;
                    w_ptr_nxt   = r_adr + 3'd1;
                    w_tmo_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_adr   <= 3'd0;
            r_ptr   <= 3'd0;
`ifdef RR_ENC_TIMEOUT_EN
            r_cnt   <= 8'd0;
            r_tmo   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_adr   <= w_adr_nxt;
            r_ptr   <= w_ptr_nxt;
`ifdef RR_ENC_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
`endif
        end
    end

    assign adr0  = r_adr[2];
    assign adr1  = r_adr[1];
    assign adr2  = r_adr[0];
    assign valid = (r_state == c_GRANT);
    assign busy  = (r_state == c_GRANT);
`ifdef RR_ENC_TIMEOUT_EN
    assign timeout_err = r_tmo;
`endif

endmodule
`default_nettype wire

// File: tb/tb_request_encoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_request_encoder_arbiter
// Brief    : Self-checking bench for request_encoder_arbiter (round-robin build,
//            watchdog scenarios included when RR_ENC_TIMEOUT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_request_encoder_arbiter;

    localparam int c_TMO = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req_x;
    logic       ack;
    logic       adr0;
    logic       adr1;
    logic       adr2;
    logic       valid;
    logic       busy;
`ifdef RR_ENC_TIMEOUT_EN
    logic       timeout_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int m_ptr    = 0;

    request_encoder_arbiter #(
        .FIXED_PRIO     (0),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_x       (req_x),
        .ack         (ack),
        .adr0        (adr0),
        .adr1        (adr1),
        .adr2        (adr2),
        .valid       (valid),
        .busy        (busy)
`ifdef RR_ENC_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int obs_idx();
        return int'({adr0, adr1, adr2});
    endfunction

    // Reference round-robin choice: first requester scanning from ptr upward.
    function automatic int rr_pick(input int ptr, input logic [7:0] rq);
        for (int k = 0; k < 8; k++) begin
            if (rq[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_x = 8'h00; ack = 1'b0;
        tick();
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_x = 8'hFF; ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (valid !== 1'b0 || busy !== 1'b0 || obs_idx() !== 0)
                $display("FAIL reset_c%0d: valid=%b busy=%b adr=%0d required 0/0/0", c, valid, busy, obs_idx());
            else n_pass++;
            ack = 1'b1;
        end
        rst = 1'b0; ack = 1'b0;
        tick();
        n_checks++;
        if (valid !== 1'b1 || obs_idx() !== 0)
            $display("FAIL reset_first_grant: valid=%b adr=%0d required 1/0", valid, obs_idx());
        else n_pass++;
        ack = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b0) $display("FAIL reset_ack_drop: valid=%b required 0", valid);
        else n_pass++;
        ack = 1'b0; req_x = 8'h00;
        m_ptr = 1;
    endtask

    task automatic test_single();
        logic [7:0] sel;
        int exp_idx;
        exp_idx = rr_pick(m_ptr, 8'b0000_0010);
        req_x = 8'b0000_0010;
        tick();
        sel = valid ? (8'b1 << obs_idx()) : 8'h00;
        n_checks++;
        if (valid !== 1'b1 || obs_idx() !== exp_idx)
            $display("FAIL single_grant: valid=%b adr=%0d required 1/%0d", valid, obs_idx(), exp_idx);
        else n_pass++;
        n_checks++;
        if (sel !== 8'b0000_0010) $display("FAIL single_decode: sel=%b required 00000010", sel);
        else n_pass++;
        ack = 1'b1; req_x = 8'h00;
        tick();
        n_checks++;
        if (valid !== 1'b0 || obs_idx() !== 1)
            $display("FAIL single_release: valid=%b adr=%0d required 0/1 (retained)", valid, obs_idx());
        else n_pass++;
        ack = 1'b0;
        m_ptr = (exp_idx + 1) % 8;
    endtask

    task automatic test_rr_fairness();
        int exp_idx;
        do_reset();
        req_x = 8'hFF; ack = 1'b1;
        for (int g = 0; g < 9; g++) begin
            exp_idx = rr_pick(m_ptr, 8'hFF);
            tick();
            n_checks++;
            if (valid !== 1'b1 || obs_idx() !== exp_idx)
                $display("FAIL rr_grant_%0d: valid=%b adr=%0d required 1/%0d", g, valid, obs_idx(), exp_idx);
            else n_pass++;
            m_ptr = (exp_idx + 1) % 8;
            tick();
            n_checks++;
            if (valid !== 1'b0) $display("FAIL rr_gap_%0d: valid=%b required 0", g, valid);
            else n_pass++;
        end
        req_x = 8'h00; ack = 1'b0;
    endtask

    task automatic test_wrap_skip();
        do_reset();
        req_x = 8'b0010_0000;
        tick();
        n_checks++;
        if (valid !== 1'b1 || obs_idx() !== 5)
            $display("FAIL wrap_setup: valid=%b adr=%0d required 1/5", valid, obs_idx());
        else n_pass++;
        ack = 1'b1; req_x = 8'h00;
        tick();
        req_x = 8'b0010_0001;
        tick();
        n_checks++;
        if (valid !== 1'b1 || obs_idx() !== 0)
            $display("FAIL wrap_first: valid=%b adr=%0d required 1/0", valid, obs_idx());
        else n_pass++;
        tick();
        n_checks++;
        if (valid !== 1'b0) $display("FAIL wrap_gap: valid=%b required 0", valid);
        else n_pass++;
        tick();
        n_checks++;
        if (valid !== 1'b1 || {adr0, adr1, adr2} !== 3'b101)
            $display("FAIL wrap_second: valid=%b adr=%b%b%b required 1/101", valid, adr0, adr1, adr2);
        else n_pass++;
        req_x = 8'h00;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_hold();
`ifdef RR_ENC_TIMEOUT_EN
        int n_hold = c_TMO - 1;
`else
        int n_hold = 5;
`endif
        do_reset();
        req_x = 8'b0000_1000;
        tick();
        req_x = 8'h00;
        for (int c = 0; c < n_hold; c++) begin
            tick();
            n_checks++;
            if (valid !== 1'b1 || busy !== 1'b1 || {adr0, adr1, adr2} !== 3'b011)
                $display("FAIL hold_c%0d: valid=%b busy=%b adr=%b%b%b required 1/1/011", c, valid, busy, adr0, adr1, adr2);
            else n_pass++;
        end
        ack = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b0) $display("FAIL hold_release: valid=%b required 0", valid);
        else n_pass++;
`ifdef RR_ENC_TIMEOUT_EN
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL hold_ack_at_limit: timeout_err=%b required 0", timeout_err);
        else n_pass++;
`endif
        ack = 1'b0;
    endtask

`ifdef RR_ENC_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req_x = 8'b0000_0100;
        for (int c = 0; c < c_TMO; c++) begin
            tick();
            req_x = 8'h00;
            n_checks++;
            if (valid !== 1'b1 || obs_idx() !== 2 || timeout_err !== 1'b0)
                $display("FAIL tmo_grant_c%0d: valid=%b adr=%0d terr=%b required 1/2/0", c, valid, obs_idx(), timeout_err);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (valid !== 1'b0 || timeout_err !== 1'b1)
            $display("FAIL tmo_expire: valid=%b terr=%b required 0/1", valid, timeout_err);
        else n_pass++;
        req_x = 8'hFF;
        tick();
        n_checks++;
        if (valid !== 1'b1 || obs_idx() !== 3 || timeout_err !== 1'b0)
            $display("FAIL tmo_next: valid=%b adr=%0d terr=%b required 1/3/0", valid, obs_idx(), timeout_err);
        else n_pass++;
        req_x = 8'h00; ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask
`endif

    // Random requests, acks and occasional resets against a transaction-level model.
    task automatic test_random();
        logic       m_valid = 1'b0;
        int         m_idx   = 0;
        int         m_age   = 0;
        logic       m_terr  = 1'b0;
        logic       rs;
        logic [7:0] rq;
        logic       ak;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rs = ($urandom_range(0, 63) == 0);
            rq = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            ak = 1'($urandom_range(0, 1));
            rst = rs; req_x = rq; ack = ak;
            tick();
            m_terr = 1'b0;
            if (rs) begin
                m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_age = 0;
            end else if (!m_valid) begin
                if (rq != 8'h00) begin
                    m_idx = rr_pick(m_ptr, rq); m_valid = 1'b1; m_age = 0;
                end
            end else if (ak) begin
                m_valid = 1'b0; m_ptr = (m_idx + 1) % 8;
            end else begin
                m_age = m_age + 1;
`ifdef RR_ENC_TIMEOUT_EN
                if (m_age == c_TMO) begin
                    m_valid = 1'b0; m_ptr = (m_idx + 1) % 8; m_terr = 1'b1;
                end
`endif
            end
            n_checks++;
            if (valid !== m_valid || busy !== m_valid || obs_idx() !== m_idx)
                $display("FAIL random_c%0d: valid=%b busy=%b adr=%0d required %b/%b/%0d", c, valid, busy, obs_idx(), m_valid, m_valid, m_idx);
            else n_pass++;
`ifdef RR_ENC_TIMEOUT_EN
            n_checks++;
            if (timeout_err !== m_terr)
                $display("FAIL random_terr_c%0d: timeout_err=%b required %b", c, timeout_err, m_terr);
            else n_pass++;
`endif
        end
        rst = 1'b0; req_x = 8'h00; ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_x = 8'h00; ack = 1'b0;
        test_reset();
        test_single();
        test_rr_fairness();
        test_wrap_skip();
        test_hold();
`ifdef RR_ENC_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
